// File: rtl/trig_request_scheduler_pkg.sv
// Shared definitions for the trig request scheduler: op codes, angle constants and FSM states.
package trig_request_scheduler_pkg;

    localparam int unsigned DEF_ANGLE_W    = 10;
    localparam int unsigned DEF_FULL_TURN  = 360;
    localparam int unsigned DEF_SIN_OFFSET = 270;

    localparam logic OP_COS = 1'b0;
    localparam logic OP_SIN = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReduce = 3'd1,
        StMap    = 3'd2,
        StLook   = 3'd3,
        StResp   = 3'd4
    } state_e;

endpackage

// File: rtl/trig_request_scheduler_cosinus_value.sv
// Combinational cosine lookup for integer degrees 0..359, returning |cos| as three BCD
// digits (x.yz, rounded to hundredths) plus a sign bit.
module cosinus_value (
    input  logic [8:0] sayi,
    output logic [3:0] tam,
    output logic [3:0] virgul1,
    output logic [3:0] virgul2,
    output logic       sign
);

    function automatic logic [6:0] cos_hundredths(input logic [8:0] d);
        logic [6:0] v;
        v = 7'd0;
        case (d)
            9'd0:  v = 7'd100; 9'd1:  v = 7'd100; 9'd2:  v = 7'd100; 9'd3:  v = 7'd100;
            9'd4:  v = 7'd100; 9'd5:  v = 7'd100; 9'd6:  v = 7'd99;  9'd7:  v = 7'd99;
            9'd8:  v = 7'd99;  9'd9:  v = 7'd99;  9'd10: v = 7'd98;  9'd11: v = 7'd98;
            9'd12: v = 7'd98;  9'd13: v = 7'd97;  9'd14: v = 7'd97;  9'd15: v = 7'd97;
            9'd16: v = 7'd96;  9'd17: v = 7'd96;  9'd18: v = 7'd95;  9'd19: v = 7'd95;
            9'd20: v = 7'd94;  9'd21: v = 7'd93;  9'd22: v = 7'd93;  9'd23: v = 7'd92;
            9'd24: v = 7'd91;  9'd25: v = 7'd91;  9'd26: v = 7'd90;  9'd27: v = 7'd89;
            9'd28: v = 7'd88;  9'd29: v = 7'd87;  9'd30: v = 7'd87;  9'd31: v = 7'd86;
            9'd32: v = 7'd85;  9'd33: v = 7'd84;  9'd34: v = 7'd83;  9'd35: v = 7'd82;
            9'd36: v = 7'd81;  9'd37: v = 7'd80;  9'd38: v = 7'd79;  9'd39: v = 7'd78;
            9'd40: v = 7'd77;  9'd41: v = 7'd75;  9'd42: v = 7'd74;  9'd43: v = 7'd73;
            9'd44: v = 7'd72;  9'd45: v = 7'd71;  9'd46: v = 7'd69;  9'd47: v = 7'd68;
            9'd48: v = 7'd67;  9'd49: v = 7'd66;  9'd50: v = 7'd64;  9'd51: v = 7'd63;
            9'd52: v = 7'd62;  9'd53: v = 7'd60;  9'd54: v = 7'd59;  9'd55: v = 7'd57;
            9'd56: v = 7'd56;  9'd57: v = 7'd54;  9'd58: v = 7'd53;  9'd59: v = 7'd52;
            9'd60: v = 7'd50;  9'd61: v = 7'd48;  9'd62: v = 7'd47;  9'd63: v = 7'd45;
            9'd64: v = 7'd44;  9'd65: v = 7'd42;  9'd66: v = 7'd41;  9'd67: v = 7'd39;
            9'd68: v = 7'd37;  9'd69: v = 7'd36;  9'd70: v = 7'd34;  9'd71: v = 7'd33;
            9'd72: v = 7'd31;  9'd73: v = 7'd29;  9'd74: v = 7'd28;  9'd75: v = 7'd26;
            9'd76: v = 7'd24;  9'd77: v = 7'd22;  9'd78: v = 7'd21;  9'd79: v = 7'd19;
            9'd80: v = 7'd17;  9'd81: v = 7'd16;  9'd82: v = 7'd14;  9'd83: v = 7'd12;
            9'd84: v = 7'd10;  9'd85: v = 7'd9;   9'd86: v = 7'd7;   9'd87: v = 7'd5;
            9'd88: v = 7'd3;   9'd89: v = 7'd2;   9'd90: v = 7'd0;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    logic [8:0] idx;
    logic [6:0] hund;
    logic [6:0] frac;

    // Fold the full circle onto the first quadrant; 90 and 270 give 0.00 with a positive sign.
    always_comb begin
        idx  = sayi;
        sign = 1'b0;
        if (sayi <= 9'd90) begin
            idx = sayi;
        end else if (sayi <= 9'd180) begin
            idx  = 9'd180 - sayi;
            sign = 1'b1;
        end else if (sayi < 9'd270) begin
            idx  = sayi - 9'd180;
            sign = 1'b1;
        end else begin
            idx = 9'd360 - sayi;
        end
        hund    = cos_hundredths(idx);
        tam     = (hund >= 7'd100) ? 4'd1 : 4'd0;
        frac    = (hund >= 7'd100) ? 7'd0 : hund;
        virgul1 = 4'(frac / 7'd10);
        virgul2 = 4'(frac % 7'd10);
    end

endmodule

// File: rtl/trig_request_scheduler.sv
// Round-robin front end sharing one cosinus_value lookup between two requesters; reduces the
// angle modulo a full turn, maps sin onto cos and returns a registered BCD result.
module trig_request_scheduler
    import trig_request_scheduler_pkg::*;
#(
    parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
    parameter int unsigned FULL_TURN  = DEF_FULL_TURN,
    parameter int unsigned SIN_OFFSET = DEF_SIN_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_op,
    input  logic [ANGLE_W-1:0] req_angle0,
    input  logic [ANGLE_W-1:0] req_angle1,
    output logic [1:0]         req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [3:0]         rsp_tam,
    output logic [3:0]         rsp_virgul1,
    output logic [3:0]         rsp_virgul2,
    output logic               rsp_sign,
    output logic               busy
);

    state_e             state_q, state_d;
    logic               rr_last_q;
    logic [ANGLE_W-1:0] a_q, a_d;
    logic               op_q;
    logic               id_q;
    logic [1:0]         grant;
    logic               accept;
    logic               accept_id;
    logic [ANGLE_W:0]   sum;

    logic [3:0]         lut_tam, lut_v1, lut_v2;
    logic               lut_sign;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign accept_id = grant[1];
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sum     = {1'b0, a_q} + (ANGLE_W+1)'(SIN_OFFSET);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReduce;
                    a_d     = accept_id ? req_angle1 : req_angle0;
                end
            end
            StReduce: begin
                if (a_q >= ANGLE_W'(FULL_TURN)) begin
                    a_d = a_q - ANGLE_W'(FULL_TURN);
                end else begin
                    state_d = StMap;
                end
            end
            StMap: begin
                // a < FULL_TURN here, so one conditional subtract completes the modulo.
                if (op_q == OP_SIN) begin
                    if (sum >= (ANGLE_W+1)'(FULL_TURN)) begin
                        a_d = ANGLE_W'(sum - (ANGLE_W+1)'(FULL_TURN));
                    end else begin
                        a_d = ANGLE_W'(sum);
                    end
                end
                state_d = StLook;
            end
            StLook: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    cosinus_value u_cosinus_value (
        .sayi    (a_q[8:0]),
        .tam     (lut_tam),
        .virgul1 (lut_v1),
        .virgul2 (lut_v2),
        .sign    (lut_sign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_last_q   <= 1'b1;
            a_q         <= '0;
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_tam     <= 4'd0;
            rsp_virgul1 <= 4'd0;
            rsp_virgul2 <= 4'd0;
            rsp_sign    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            if (accept) begin
                op_q      <= accept_id ? req_op[1] : req_op[0];
                id_q      <= accept_id;
                rr_last_q <= accept_id;
            end
            if (state_q == StLook) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= id_q;
                rsp_tam     <= lut_tam;
                rsp_virgul1 <= lut_v1;
                rsp_virgul2 <= lut_v2;
                rsp_sign    <= lut_sign;
            end else if (state_d == StIdle) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trig_request_scheduler.sv
// Scoreboard bench for trig_request_scheduler: directed scenarios plus random traffic checked
// against a real-arithmetic cosine model.
module tb_trig_request_scheduler;

    localparam real PI = 3.14159265358979;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_op = 2'b00;
    logic [9:0] req_angle0 = 10'd0;
    logic [9:0] req_angle1 = 10'd0;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [3:0] rsp_tam, rsp_virgul1, rsp_virgul2;
    logic       rsp_sign;
    logic       busy;

    trig_request_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_angle0  (req_angle0),
        .req_angle1  (req_angle1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_tam     (rsp_tam),
        .rsp_virgul1 (rsp_virgul1),
        .rsp_virgul2 (rsp_virgul2),
        .rsp_sign    (rsp_sign),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int tam;
        int v1;
        int v2;
        int sign;
        int due;
    } exp_t;

    exp_t exp_mem [256];
    int   wr = 0;       // written by the stimulus process only
    int   rd = 0;       // written by the monitor only
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rr_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int id, input int op, input int ang);
        exp_t e;
        int   a;
        int   r;
        real  c;
        real  m;
        a = ang % 360;
        if (op == 1) a = (a + 270) % 360;
        c = $cos(a * PI / 180.0);
        m = (c < 0.0) ? -c : c;
        r = int'(m * 100.0);
        e.id   = id;
        e.tam  = r / 100;
        e.v1   = (r % 100) / 10;
        e.v2   = r % 10;
        e.sign = (c < 0.0 && r != 0) ? 1 : 0;
        e.due  = 0;
        return e;
    endfunction

    // One cycle of stimulus; predicts the grant and, on acceptance, scoreboards the response.
    task automatic step(input logic [1:0] v, input logic [1:0] op, input logic [9:0] a0,
                        input logic [9:0] a1, input logic rr);
        logic [1:0] exp_g;
        logic       model_busy;
        exp_t       e;
        int         id;
        int         ang;
        @(negedge clk);
        req_valid  = v;
        req_op     = op;
        req_angle0 = a0;
        req_angle1 = a1;
        rsp_ready  = rr;
        #1;
        model_busy = (wr != rd);
        exp_g = 2'b00;
        if (!model_busy) begin
            if (v == 2'b01) exp_g = 2'b01;
            else if (v == 2'b10) exp_g = 2'b10;
            else if (v == 2'b11) exp_g = rr_last ? 2'b01 : 2'b10;
        end
        chk("req_ready", int'(req_ready), int'(exp_g));
        chk("busy", int'(busy), int'(model_busy));
        if (exp_g != 2'b00) begin
            id  = exp_g[1] ? 1 : 0;
            ang = exp_g[1] ? int'(a1) : int'(a0);
            e = model(id, exp_g[1] ? int'(op[1]) : int'(op[0]), ang);
            e.due = cyc + 4 + ang / 360;
            exp_mem[wr % 256] = e;
            wr++;
            rr_last = exp_g[1];
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && wr != rd; n++) step(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
        chk("drain", wr - rd, 0);
    endtask

    function automatic logic [9:0] pick_angle();
        int unsigned s;
        logic [9:0] edge_tab [8];
        edge_tab = '{10'd0, 10'd90, 10'd270, 10'd359, 10'd360, 10'd719, 10'd720, 10'd1023};
        s = $urandom_range(0, 3);
        if (s == 0) return edge_tab[$urandom_range(0, 7)];
        return 10'($urandom_range(0, 1023));
    endfunction

    // Monitor: compares each presented response against the scoreboard head and checks stability.
    initial begin
        exp_t cur;
        bit   holding;
        holding = 1'b0;
        cur = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                rd = wr;
                holding = 1'b0;
            end else if (rsp_valid) begin
                if (!holding) begin
                    if (rd == wr) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        cur = exp_mem[rd % 256];
                        holding = 1'b1;
                        chk("latency", cyc, cur.due);
                    end
                end
                if (holding) begin
                    chk("rsp_id", int'(rsp_id), cur.id);
                    chk("rsp_tam", int'(rsp_tam), cur.tam);
                    chk("rsp_virgul1", int'(rsp_virgul1), cur.v1);
                    chk("rsp_virgul2", int'(rsp_virgul2), cur.v2);
                    chk("rsp_sign", int'(rsp_sign), cur.sign);
                end
                if (rsp_ready) begin
                    holding = 1'b0;
                    if (rd != wr) rd++;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rsp_tam", int'(rsp_tam), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios.
        step(2'b01, 2'b00, 10'd60, 10'd0, 1'b1);
        wait_idle();
        step(2'b10, 2'b10, 10'd0, 10'd30, 1'b1);
        wait_idle();
        step(2'b01, 2'b00, 10'd900, 10'd0, 1'b1);
        wait_idle();
        for (int i = 0; i < 24; i++) step(2'b11, 2'b00, 10'd0, 10'd0, 1'b1);
        wait_idle();
        step(2'b01, 2'b00, 10'd45, 10'd0, 1'b1);
        for (int i = 0; i < 14; i++) step(2'b10, 2'b00, 10'd0, 10'd77, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 10'd0, 10'd77, 1'b1);
        wait_idle();

        // Reset while reducing a large angle.
        step(2'b01, 2'b00, 10'd1000, 10'd0, 1'b1);
        step(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_tam", int'(rsp_tam), 0);
        chk("rst_rsp_virgul1", int'(rsp_virgul1), 0);
        chk("rst_rsp_virgul2", int'(rsp_virgul2), 0);
        chk("rst_rsp_sign", int'(rsp_sign), 0);
        rr_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(2'b01, 2'b00, 10'd90, 10'd0, 1'b1);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick_angle(), pick_angle(),
                 ($urandom_range(0, 3) != 0));
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
